// File: rtl/packet_filter_pkg.sv
// packet_filter_pkg: constants shared by the packet filter and its shadow
// register file (packet types, frame word indices, FSM state encoding).
package packet_filter_pkg;

  localparam int FRAME_WORDS = 8;

  // Packet types that the Q-table updater understands
  localparam logic [2:0] PT_HELLO  = 3'b001;
  localparam logic [2:0] PT_CH_ADV = 3'b010;
  localparam logic [2:0] PT_JOIN   = 3'b011;
  localparam logic [2:0] PT_ACK    = 3'b100;
  localparam logic [2:0] PT_DATA   = 3'b101;

  // Position of each field inside the 8-word frame
  localparam logic [2:0] W_TYPE    = 3'd0;
  localparam logic [2:0] W_DEST    = 3'd1;
  localparam logic [2:0] W_SRC     = 3'd2;
  localparam logic [2:0] W_HOPS    = 3'd3;
  localparam logic [2:0] W_CLUSTER = 3'd4;
  localparam logic [2:0] W_ENERGY  = 3'd5;
  localparam logic [2:0] W_QVALUE  = 3'd6;
  localparam logic [2:0] W_KNOWNCH = 3'd7;

  // FSM state encoding
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RECV      = 3'd1;
  localparam logic [2:0] S_CHECK     = 3'd2;
  localparam logic [2:0] S_ISSUE     = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;

  // True for the packet types forwarded to the updater
  function automatic logic type_ok(input logic [2:0] t);
    return (t == PT_HELLO) || (t == PT_CH_ADV) || (t == PT_JOIN) ||
           (t == PT_ACK)   || (t == PT_DATA);
  endfunction

endpackage

// File: rtl/packet_filter_fields.sv
// pkt_field_regs: 8-entry shadow register file holding the frame being
// received. One indexed write port, all entries readable in parallel.
module pkt_field_regs
  import packet_filter_pkg::*;
#(
  parameter int WORD_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic                              wr_en_i,
  input  logic [2:0]                        wr_idx_i,
  input  logic [WORD_WIDTH-1:0]             wr_data_i,
  output logic [FRAME_WORDS*WORD_WIDTH-1:0] rd_words_o
);

  generate
    for (genvar gi = 0; gi < FRAME_WORDS; gi++) begin : g_word
      logic [WORD_WIDTH-1:0] word_q;

      // Capture the incoming word when it targets this entry
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          word_q <= '0;
        end else if (wr_en_i && (wr_idx_i == 3'(gi))) begin
          word_q <= wr_data_i;
        end
      end

      assign rd_words_o[gi*WORD_WIDTH +: WORD_WIDTH] = word_q;
    end
  endgenerate

endmodule

// File: rtl/packet_filter.sv
// packet_filter: receives 8-word frames, filters on destination and packet
// type, publishes accepted headers on the f* bus and hands off to the
// Q-table updater (en/done handshake with timeout).
// Optional statistics counters: define PKT_FILTER_STATS_EN.
module packet_filter
  import packet_filter_pkg::*;
#(
  parameter int                    WORD_WIDTH   = 16,
  parameter logic [WORD_WIDTH-1:0] NODE_ID      = 16'h0000,
  parameter logic [WORD_WIDTH-1:0] BCAST_ID     = 16'hFFFF,
  parameter int                    DONE_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_sof,
  output logic                  in_ready,
  input  logic                  done,
  output logic                  en,
  output logic [2:0]            fPacketType,
  output logic [WORD_WIDTH-1:0] fSourceID,
  output logic [WORD_WIDTH-1:0] fSourceHops,
  output logic [WORD_WIDTH-1:0] fClusterID,
  output logic [WORD_WIDTH-1:0] fEnergyLeft,
  output logic [WORD_WIDTH-1:0] fQValue,
  output logic [WORD_WIDTH-1:0] fKnownCH,
  output logic                  busy,
  output logic                  timeout_err
`ifdef PKT_FILTER_STATS_EN
  ,
  output logic [15:0]           rx_count,
  output logic [15:0]           drop_count
`endif
);

  localparam int TW = $clog2(DONE_TIMEOUT);
  localparam logic [TW-1:0] WAIT_LAST = TW'(DONE_TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] wait_q, wait_d;
  logic          terr_q, terr_d;
  logic          en_q, busy_q;
  logic          xfer, wr_en, accept, frame_ok;
  logic [2:0]    wr_idx;

  logic [FRAME_WORDS*WORD_WIDTH-1:0] rd_words;
  logic [WORD_WIDTH-1:0] w_type, w_dest, w_src, w_hops, w_cluster, w_energy, w_qvalue, w_knownch;
  logic                  type_word_unused;

  logic [2:0]            f_type_q;
  logic [WORD_WIDTH-1:0] f_src_q, f_hops_q, f_cluster_q, f_energy_q, f_qvalue_q, f_knownch_q;

  pkt_field_regs #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_fields (
    .clk       (clk),
    .nrst      (nrst),
    .wr_en_i   (wr_en),
    .wr_idx_i  (wr_idx),
    .wr_data_i (in_data),
    .rd_words_o(rd_words)
  );

  assign w_type    = rd_words[int'(W_TYPE)*WORD_WIDTH    +: WORD_WIDTH];
  assign w_dest    = rd_words[int'(W_DEST)*WORD_WIDTH    +: WORD_WIDTH];
  assign w_src     = rd_words[int'(W_SRC)*WORD_WIDTH     +: WORD_WIDTH];
  assign w_hops    = rd_words[int'(W_HOPS)*WORD_WIDTH    +: WORD_WIDTH];
  assign w_cluster = rd_words[int'(W_CLUSTER)*WORD_WIDTH +: WORD_WIDTH];
  assign w_energy  = rd_words[int'(W_ENERGY)*WORD_WIDTH  +: WORD_WIDTH];
  assign w_qvalue  = rd_words[int'(W_QVALUE)*WORD_WIDTH  +: WORD_WIDTH];
  assign w_knownch = rd_words[int'(W_KNOWNCH)*WORD_WIDTH +: WORD_WIDTH];

  // Only bits [2:0] of the type word carry meaning
  assign type_word_unused = ^w_type[WORD_WIDTH-1:3];

  assign in_ready = (state_q == S_IDLE) || (state_q == S_RECV);
  assign xfer     = in_valid && in_ready;
  assign frame_ok = ((w_dest == NODE_ID) || (w_dest == BCAST_ID)) && type_ok(w_type[2:0]);

  // Next-state logic: frame assembly, filter decision and done/timeout wait
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    terr_d  = terr_q;
    wr_en   = 1'b0;
    wr_idx  = cnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (xfer && in_sof) begin
          wr_en   = 1'b1;
          wr_idx  = W_TYPE;
          cnt_d   = 3'd1;
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (xfer) begin
          wr_en = 1'b1;
          if (in_sof) begin
            // a new start-of-frame abandons the partial frame
            wr_idx = W_TYPE;
            cnt_d  = 3'd1;
          end else if (cnt_q == W_KNOWNCH) begin
            cnt_d   = 3'd0;
            state_d = S_CHECK;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      S_CHECK: begin
        accept  = frame_ok;
        state_d = frame_ok ? S_ISSUE : S_IDLE;
      end
      S_ISSUE: begin
        wait_d  = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // done wins over a simultaneous expiry
        if (done) begin
          state_d = S_IDLE;
        end else if (wait_q == WAIT_LAST) begin
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state registers; en and busy are registered from the next state
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      terr_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      terr_q  <= terr_d;
      en_q    <= (state_d == S_ISSUE);
      busy_q  <= (state_d == S_ISSUE) || (state_d == S_WAIT_DONE);
    end
  end

  // Publish the header fields of an accepted frame; hold them otherwise
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      f_type_q    <= '0;
      f_src_q     <= '0;
      f_hops_q    <= '0;
      f_cluster_q <= '0;
      f_energy_q  <= '0;
      f_qvalue_q  <= '0;
      f_knownch_q <= '0;
    end else if (accept) begin
      f_type_q    <= w_type[2:0];
      f_src_q     <= w_src;
      f_hops_q    <= w_hops;
      f_cluster_q <= w_cluster;
      f_energy_q  <= w_energy;
      f_qvalue_q  <= w_qvalue;
      f_knownch_q <= w_knownch;
    end
  end

`ifdef PKT_FILTER_STATS_EN
  logic [15:0] rx_cnt_q, drop_cnt_q;

  // Saturating counts of accepted and rejected frames, decided in CHECK
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else if (state_q == S_CHECK) begin
      if (frame_ok && (rx_cnt_q != 16'hFFFF)) begin
        rx_cnt_q <= rx_cnt_q + 16'd1;
      end
      if (!frame_ok && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign rx_count   = rx_cnt_q;
  assign drop_count = drop_cnt_q;
`endif

  assign en          = en_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;
  assign fPacketType = f_type_q;
  assign fSourceID   = f_src_q;
  assign fSourceHops = f_hops_q;
  assign fClusterID  = f_cluster_q;
  assign fEnergyLeft = f_energy_q;
  assign fQValue     = f_qvalue_q;
  assign fKnownCH    = f_knownch_q;

endmodule

// File: tb/tb_packet_filter.sv
// tb_packet_filter: directed and randomized frames against a reference model
// of the filter rules; expected header publications go into a scoreboard that
// a separate monitor checks on every en pulse.
module tb_packet_filter;

  localparam logic [15:0] NODE = 16'd15;
  localparam int          DT   = 16;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic        done = 1'b0;
  logic        in_ready, en, busy, timeout_err;
  logic [2:0]  fPacketType;
  logic [15:0] fSourceID, fSourceHops, fClusterID, fEnergyLeft, fQValue, fKnownCH;
`ifdef PKT_FILTER_STATS_EN
  logic [15:0] rx_count, drop_count;
`endif

  packet_filter #(
    .WORD_WIDTH  (16),
    .NODE_ID     (NODE),
    .BCAST_ID    (16'hFFFF),
    .DONE_TIMEOUT(DT)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_ready   (in_ready),
    .done       (done),
    .en         (en),
    .fPacketType(fPacketType),
    .fSourceID  (fSourceID),
    .fSourceHops(fSourceHops),
    .fClusterID (fClusterID),
    .fEnergyLeft(fEnergyLeft),
    .fQValue    (fQValue),
    .fKnownCH   (fKnownCH),
    .busy       (busy),
    .timeout_err(timeout_err)
`ifdef PKT_FILTER_STATS_EN
    ,
    .rx_count   (rx_count),
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [98:0] f;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];

  logic [15:0] fr[8];
  logic [98:0] last_f = '0;
  int          rx_m = 0, drop_m = 0, acc_total = 0, en_seen = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [98:0] dut_fields();
    return {fPacketType, fSourceID, fSourceHops, fClusterID, fEnergyLeft, fQValue, fKnownCH};
  endfunction

  // Filter rule: addressed to us or broadcast, and a type in 1..5
  function automatic bit model_accept(input logic [15:0] t, input logic [15:0] d);
    int ty;
    ty = int'(t[2:0]);
    return ((d == NODE) || (d == 16'hFFFF)) && (ty >= 1) && (ty <= 5);
  endfunction

  task automatic set_frame(input logic [15:0] t, d, s, h, c, e, q, k);
    fr[0] = t; fr[1] = d; fr[2] = s; fr[3] = h;
    fr[4] = c; fr[5] = e; fr[6] = q; fr[7] = k;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [15:0] d, input logic sof, input int gaps);
    repeat (gaps) begin
      in_valid = 1'b0;
      in_sof   = 1'($urandom_range(0, 1));
      in_data  = 16'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    check("in_ready_rx", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // Sends fr; n = cycle number of the edge that transferred word 7
  task automatic send_frame(input int max_gap, output int n);
    for (int i = 0; i < 8; i++) begin
      send_word(fr[i], (i == 0), $urandom_range(0, max_gap));
    end
    n = cyc;
  endtask

  task automatic check_stats();
`ifdef PKT_FILTER_STATS_EN
    check("rx_count", rx_count, rx_m);
    check("drop_count", drop_count, drop_m);
`endif
  endtask

  // Model the filter outcome for fr; done_dly < 0 means done is withheld
  task automatic process_frame(input int n, input int done_dly);
    exp_t e;
    if (model_accept(fr[0], fr[1])) begin
      e.f   = {fr[0][2:0], fr[2], fr[3], fr[4], fr[5], fr[6], fr[7]};
      e.cyc = n + 1;
      sb_q.push_back(e);
      last_f = e.f;
      rx_m++;
      acc_total++;
      if (done_dly >= 0) begin
        wait_until(n + 1 + done_dly);
        check("busy_wait", busy, 1'b1);
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        check("busy_after_done", busy, 1'b0);
        check("ready_after_done", in_ready, 1'b1);
        check_stats();
      end
    end else begin
      drop_m++;
      wait_until(n + 3);
      check("hold_on_reject", dut_fields(), last_f);
      check("ready_after_reject", in_ready, 1'b1);
      check("busy_after_reject", busy, 1'b0);
      check_stats();
    end
  endtask

  // Monitor: each en pulse must match the next scoreboard entry
  logic en_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (nrst && en) begin
        en_seen++;
        check("en_one_cycle", en_prev, 1'b0);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_en: en high at cycle %0d, expected no pulse", cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("fields", dut_fields(), e.f);
          check("en_cycle", cyc, e.cyc);
        end
      end
      en_prev = en;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    #12;
    check("rst_ready", in_ready, 1'b1);
    check("rst_ctrl", {en, busy, timeout_err}, 3'b000);
    check("rst_fields", dut_fields(), 99'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Accepted frame, done 5 cycles after en
    set_frame(16'h0005, NODE, 16'd1, 16'd2, 16'd2, 16'h8000, 16'h3000, 16'd15);
    send_frame(0, n);
    process_frame(n, 5);

    // Broadcast accepted; done coincident with timeout expiry counts as done
    set_frame(16'h0001, 16'hFFFF, 16'd7, 16'd1, 16'd3, 16'h1234, 16'h0042, 16'd9);
    send_frame(0, n);
    process_frame(n, DT);
    check("no_terr_on_late_done", timeout_err, 1'b0);

    // Wrong destination rejected
    set_frame(16'h0002, 16'd17, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5);
    send_frame(0, n);
    process_frame(n, 1);

    // Type filtering, then an accepted DATA frame
    for (int t = 0; t < 3; t++) begin
      logic [2:0] bad_types[3];
      bad_types[0] = 3'b000; bad_types[1] = 3'b110; bad_types[2] = 3'b111;
      set_frame({13'h1ABC, bad_types[t]}, NODE, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9);
      send_frame(0, n);
      process_frame(n, 1);
    end
    set_frame(16'h0005, NODE, 16'd17, 16'd4, 16'd6, 16'h1800, 16'hB800, 16'd3);
    send_frame(0, n);
    process_frame(n, 3);

    // Restart at word 4: only the second frame is published
    set_frame(16'h0003, NODE, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA);
    for (int i = 0; i < 4; i++) send_word(fr[i], (i == 0), 0);
    set_frame(16'h0004, NODE, 16'h0B0B, 16'd8, 16'd1, 16'h7FFF, 16'h0101, 16'd2);
    send_frame(0, n);
    process_frame(n, 2);

    // Gapped receive, done withheld -> timeout
    set_frame(16'h0002, NODE, 16'h0C0C, 16'd3, 16'd4, 16'h4000, 16'h2000, 16'd1);
    for (int i = 0; i < 8; i++) send_word(fr[i], (i == 0), 1);
    n = cyc;
    process_frame(n, -1);
    wait_until(n + 17);
    check("terr_before_expiry", timeout_err, 1'b0);
    check("busy_before_expiry", busy, 1'b1);
    @(posedge clk);
    #1;
    check("terr_set", timeout_err, 1'b1);
    check("busy_after_timeout", busy, 1'b0);
    check("ready_after_timeout", in_ready, 1'b1);
    done = 1'b1;
    @(posedge clk);
    #1;
    done = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("terr_sticky", timeout_err, 1'b1);
    check("busy_stray_done", busy, 1'b0);
    check_stats();

    // Reset while waiting for done
    set_frame(16'h0001, NODE, 16'd21, 16'd22, 16'd23, 16'd24, 16'd25, 16'd26);
    send_frame(0, n);
    process_frame(n, -1);
    wait_until(n + 6);
    nrst = 1'b0;
    #1;
    check("midrst_ready", in_ready, 1'b1);
    check("midrst_ctrl", {en, busy, timeout_err}, 3'b000);
    check("midrst_fields", dut_fields(), 99'd0);
    last_f = '0;
    rx_m   = 0;
    drop_m = 0;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    @(posedge clk);
    #1;
    check_stats();

    // Randomized frames
    for (int k = 0; k < 40; k++) begin
      logic [15:0] d;
      case ($urandom_range(0, 3))
        0: d = NODE;
        1: d = 16'hFFFF;
        2: d = 16'd17;
        default: d = 16'($urandom);
      endcase
      set_frame(16'($urandom), d, 16'($urandom), 16'($urandom), 16'($urandom),
                16'($urandom), 16'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 2)) send_word(16'($urandom), 1'b0, 0);
      send_frame(2, n);
      process_frame(n, $urandom_range(1, DT));
    end

    repeat (4) begin @(posedge clk); #1; end
    check("sb_drained", sb_q.size(), 0);
    check("en_count", en_seen, acc_total);
    check("terr_final", timeout_err, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
